// File: rtl/key_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// key_conditioner_pkg
//   Shared definitions for the push-button conditioner: the per-channel FSM
//   state encoding, default timing constants for a 50 MHz CLOCK_50, and a
//   helper that sizes a counter for a given cycle count.
// ---------------------------------------------------------------------------
package key_conditioner_pkg;

    // Per-channel debounce/hold state machine, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_DB_REL   = 2'd3
    } key_state_t;

    // Defaults for a 50 MHz clock: 10 ms debounce, 1 s long press, 200 ms repeat.
    localparam int DEF_NUM_KEYS      = 2;
    localparam int DEF_DB_CYCLES     = 500_000;
    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// ---------------------------------------------------------------------------
// key_conditioner_channel
//   One push-button channel: 2-flop synchroniser, debounce FSM, hold counter.
//   Emits registered single-cycle press / release / long / repeat pulses and a
//   registered debounced level.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   KEY        in   raw button, active-low, asynchronous, may bounce
//   key_level  out  debounced state, 1 = pressed (PRESSED or DB_REL)
//   key_press  out  1-cycle pulse when a press is accepted
//   key_rel    out  1-cycle pulse when a release is accepted
//   key_long   out  1-cycle pulse LONG_CYCLES after key_press, once per hold
//   key_rpt    out  1-cycle pulse every REPEAT_CYCLES after key_long while held
// ---------------------------------------------------------------------------
module key_conditioner_channel
    import key_conditioner_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic KEY,
    output logic key_level,
    output logic key_press,
    output logic key_rel,
    output logic key_long,
    output logic key_rpt
);

    localparam int DB_W   = cnt_width(DB_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES + REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RPT_FIRST  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] RPT_LAST   = HOLD_W'(LONG_CYCLES - 1 + REPEAT_CYCLES);

    logic              sync1;
    logic              sync2;
    logic              pressed_s;
    key_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;

    // Synchronised, active-high view of the button.
    assign pressed_s = ~sync2;

    // NOTE: every register here, including the synchroniser, is reset
    // synchronously; the sync flops reset to 1 so a reset reads as "released".
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= ST_IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            key_level <= 1'b0;
            key_press <= 1'b0;
            key_rel   <= 1'b0;
            key_long  <= 1'b0;
            key_rpt   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below
            // sees the value from before this edge.
            sync1 <= KEY;
            sync2 <= sync1;

            key_press <= 1'b0;
            key_rel   <= 1'b0;
            key_long  <= 1'b0;
            key_rpt   <= 1'b0;

            // Level follows the state one cycle late, so it rises the cycle
            // after key_press and falls the cycle after key_rel.
            key_level <= (state == ST_PRESSED) || (state == ST_DB_REL);

            case (state)
                ST_IDLE: begin
                    if (pressed_s) begin
                        state  <= ST_DB_PRESS;
                        db_cnt <= DB_W'(1);
                    end
                end

                ST_DB_PRESS: begin
                    if (!pressed_s) begin
                        state <= ST_IDLE;                 // bounce rejected
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        key_press <= 1'b1;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                ST_PRESSED: begin
                    // The hold counter advances on every PRESSED cycle,
                    // including the one that leaves for DB_REL.
                    if (!long_done) begin
                        if (hold_cnt == LONG_LAST) begin
                            key_long  <= 1'b1;
                            long_done <= 1'b1;
                            if (REPEAT_CYCLES != 0)
                                hold_cnt <= hold_cnt + 1'b1;  // else saturate
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (REPEAT_CYCLES != 0) begin
                        // Repeat phase cycles through LONG .. LONG-1+REPEAT,
                        // exactly REPEAT_CYCLES values, one pulse per lap.
                        if (hold_cnt == RPT_LAST) begin
                            key_rpt  <= 1'b1;
                            hold_cnt <= RPT_FIRST;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end

                    if (!pressed_s) begin
                        state  <= ST_DB_REL;
                        db_cnt <= DB_W'(1);
                    end
                end

                ST_DB_REL: begin
                    // hold_cnt is frozen here and resumes if the release was a glitch.
                    if (pressed_s) begin
                        state <= ST_PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state    <= ST_IDLE;
                        key_rel  <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//   Conditions the raw active-low DE-series push-buttons for the stopwatch /
//   watch control FSMs. One independent key_conditioner_channel per key.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   KEY        in   [NUM_KEYS] raw buttons, active-low, asynchronous
//   key_level  out  [NUM_KEYS] debounced state, 1 = pressed
//   key_press  out  [NUM_KEYS] 1-cycle pulse on accepted press
//   key_rel    out  [NUM_KEYS] 1-cycle pulse on accepted release
//   key_long   out  [NUM_KEYS] 1-cycle pulse LONG_CYCLES after key_press
//   key_rpt    out  [NUM_KEYS] 1-cycle pulse every REPEAT_CYCLES after key_long
// ---------------------------------------------------------------------------
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS      = DEF_NUM_KEYS,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_rel,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_rpt
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_conditioner_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .CLOCK_50  (CLOCK_50),
            .RESET     (RESET),
            .KEY       (KEY[i]),
            .key_level (key_level[i]),
            .key_press (key_press[i]),
            .key_rel   (key_rel[i]),
            .key_long  (key_long[i]),
            .key_rpt   (key_rpt[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//   Directed bench for key_conditioner with DB_CYCLES=4, LONG_CYCLES=20,
//   REPEAT_CYCLES=8, NUM_KEYS=2. Cycle numbering: clear_log() sets cyc=0 and
//   the KEY value driven at that moment is sampled by the next edge; after n
//   ticks cyc=n and outputs registered at that nth edge are visible.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int NK     = 2;
    localparam int DB     = 4;
    localparam int LONG_C = 20;
    localparam int RPT_C  = 8;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_RPT   = 3;

    logic          CLOCK_50 = 1'b0;
    logic          RESET;
    logic [NK-1:0] KEY;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_rel;
    logic [NK-1:0] key_long;
    logic [NK-1:0] key_rpt;

    key_conditioner #(
        .NUM_KEYS      (NK),
        .DB_CYCLES     (DB),
        .LONG_CYCLES   (LONG_C),
        .REPEAT_CYCLES (RPT_C)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .KEY       (KEY),
        .key_level (key_level),
        .key_press (key_press),
        .key_rel   (key_rel),
        .key_long  (key_long),
        .key_rpt   (key_rpt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int compared   = 0;
    int mismatched = 0;

    // Event log: per channel and kind, how many pulses and at which cycles.
    int       cyc;
    int       ev_cnt [NK][4];
    int       ev_cyc [NK][4][8];
    int       lvl_cnt[NK];
    logic [3:0] prev_p [NK];
    int       pulse_viol = 0;

    task automatic clear_log();
        cyc = 0;
        for (int ch = 0; ch < NK; ch++) begin
            lvl_cnt[ch] = 0;
            for (int k = 0; k < 4; k++) begin
                ev_cnt[ch][k] = 0;
                for (int j = 0; j < 8; j++) ev_cyc[ch][k][j] = -1;
            end
        end
    endtask

    // Advance one clock, sample just after the edge and log pulses.
    task automatic tick();
        logic [3:0] p;
        @(posedge CLOCK_50);
        #1;
        cyc++;
        for (int ch = 0; ch < NK; ch++) begin
            p = {key_rpt[ch], key_long[ch], key_rel[ch], key_press[ch]};
            for (int k = 0; k < 4; k++) begin
                if (p[k]) begin
                    if (ev_cnt[ch][k] < 8) ev_cyc[ch][k][ev_cnt[ch][k]] = cyc;
                    ev_cnt[ch][k]++;
                end
            end
            if ((p & prev_p[ch]) != 4'b0) pulse_viol++;  // pulse held two cycles
            if (p[K_PRESS] && p[K_REL]) pulse_viol++;    // press and release together
            prev_p[ch] = p;
            if (key_level[ch]) lvl_cnt[ch]++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        KEY   = 2'b11;
        repeat (3) tick();
        compared++; if (key_level !== 2'b00) begin mismatched++; $display("FAIL reset_level: got %b, expected 00", key_level); end
        compared++; if (key_press !== 2'b00) begin mismatched++; $display("FAIL reset_press: got %b, expected 00", key_press); end
        compared++; if (key_rel   !== 2'b00) begin mismatched++; $display("FAIL reset_rel: got %b, expected 00", key_rel); end
        compared++; if (key_long  !== 2'b00) begin mismatched++; $display("FAIL reset_long: got %b, expected 00", key_long); end
        compared++; if (key_rpt   !== 2'b00) begin mismatched++; $display("FAIL reset_rpt: got %b, expected 00", key_rpt); end
        RESET = 1'b0;
        clear_log();
        repeat (8) tick();
        compared++; if (ev_cnt[0][K_PRESS] + ev_cnt[1][K_PRESS] !== 0) begin mismatched++; $display("FAIL idle_no_press: got %0d presses, expected 0", ev_cnt[0][K_PRESS] + ev_cnt[1][K_PRESS]); end
    endtask

    task automatic test_clean_press();
        clear_log();
        KEY = 2'b10;
        repeat (6) tick();
        compared++; if (key_press[0] !== 1'b1) begin mismatched++; $display("FAIL press_c6: got %b, expected 1", key_press[0]); end
        compared++; if (key_level[0] !== 1'b0) begin mismatched++; $display("FAIL level_c6: got %b, expected 0", key_level[0]); end
        tick();
        compared++; if (key_level[0] !== 1'b1) begin mismatched++; $display("FAIL level_c7: got %b, expected 1", key_level[0]); end
        compared++; if (key_press[0] !== 1'b0) begin mismatched++; $display("FAIL press_c7: got %b, expected 0", key_press[0]); end
        repeat (5) tick();
        compared++; if (ev_cnt[0][K_PRESS] !== 1) begin mismatched++; $display("FAIL press_count: got %0d, expected 1", ev_cnt[0][K_PRESS]); end
        compared++; if (ev_cnt[1][K_PRESS] !== 0) begin mismatched++; $display("FAIL press_ch1_quiet: got %0d, expected 0", ev_cnt[1][K_PRESS]); end

        clear_log();
        KEY = 2'b11;
        repeat (6) tick();
        compared++; if (key_rel[0] !== 1'b1) begin mismatched++; $display("FAIL rel_c6: got %b, expected 1", key_rel[0]); end
        compared++; if (key_level[0] !== 1'b1) begin mismatched++; $display("FAIL rel_level_c6: got %b, expected 1", key_level[0]); end
        tick();
        compared++; if (key_level[0] !== 1'b0) begin mismatched++; $display("FAIL rel_level_c7: got %b, expected 0", key_level[0]); end
        repeat (4) tick();
        compared++; if (ev_cnt[0][K_REL] !== 1) begin mismatched++; $display("FAIL rel_count: got %0d, expected 1", ev_cnt[0][K_REL]); end
        compared++; if (ev_cnt[0][K_LONG] !== 0) begin mismatched++; $display("FAIL short_no_long: got %0d, expected 0", ev_cnt[0][K_LONG]); end
    endtask

    task automatic test_bounce();
        clear_log();
        KEY = 2'b10; repeat (3) tick();
        KEY = 2'b11; tick();
        KEY = 2'b10; repeat (3) tick();
        KEY = 2'b11; repeat (13) tick();
        compared++; if (ev_cnt[0][K_PRESS] !== 0) begin mismatched++; $display("FAIL bounce_press: got %0d, expected 0", ev_cnt[0][K_PRESS]); end
        compared++; if (lvl_cnt[0] !== 0) begin mismatched++; $display("FAIL bounce_level: got %0d high cycles, expected 0", lvl_cnt[0]); end
        compared++; if (ev_cnt[0][K_REL] !== 0) begin mismatched++; $display("FAIL bounce_rel: got %0d, expected 0", ev_cnt[0][K_REL]); end
    endtask

    // Press at 6, long at 26, repeats at 34/42/50; KEY rises at 52 (before a
    // fourth repeat could fire at 58) so the release pulse lands at 58.
    task automatic test_long_hold();
        int exp_rpt[3] = '{34, 42, 50};
        clear_log();
        KEY = 2'b10;
        while (cyc < 52) tick();
        KEY = 2'b11;
        while (cyc < 64) tick();
        compared++; if (ev_cyc[0][K_PRESS][0] !== 6) begin mismatched++; $display("FAIL long_press_cyc: got %0d, expected 6", ev_cyc[0][K_PRESS][0]); end
        compared++; if (ev_cnt[0][K_LONG] !== 1) begin mismatched++; $display("FAIL long_count: got %0d, expected 1", ev_cnt[0][K_LONG]); end
        compared++; if (ev_cyc[0][K_LONG][0] !== 26) begin mismatched++; $display("FAIL long_cyc: got %0d, expected 26", ev_cyc[0][K_LONG][0]); end
        compared++; if (ev_cnt[0][K_RPT] !== 3) begin mismatched++; $display("FAIL rpt_count: got %0d, expected 3", ev_cnt[0][K_RPT]); end
        for (int j = 0; j < 3; j++) begin
            compared++;
            if (ev_cyc[0][K_RPT][j] !== exp_rpt[j]) begin mismatched++; $display("FAIL rpt_cyc%0d: got %0d, expected %0d", j, ev_cyc[0][K_RPT][j], exp_rpt[j]); end
        end
        compared++; if (ev_cnt[0][K_REL] !== 1) begin mismatched++; $display("FAIL long_rel_count: got %0d, expected 1", ev_cnt[0][K_REL]); end
        compared++; if (ev_cyc[0][K_REL][0] !== 58) begin mismatched++; $display("FAIL long_rel_cyc: got %0d, expected 58", ev_cyc[0][K_REL][0]); end
        compared++; if (lvl_cnt[0] !== 52) begin mismatched++; $display("FAIL long_level_cycles: got %0d, expected 52", lvl_cnt[0]); end
    endtask

    // 2-cycle release blip at 12..13: rejected, hold counter loses 2 cycles.
    task automatic test_release_glitch();
        clear_log();
        KEY = 2'b10;
        while (cyc < 12) tick();
        KEY = 2'b11; repeat (2) tick();
        KEY = 2'b10;
        while (cyc < 30) tick();
        KEY = 2'b11;
        while (cyc < 40) tick();
        compared++; if (ev_cnt[0][K_PRESS] !== 1) begin mismatched++; $display("FAIL glitch_press_count: got %0d, expected 1", ev_cnt[0][K_PRESS]); end
        compared++; if (ev_cyc[0][K_LONG][0] !== 28) begin mismatched++; $display("FAIL glitch_long_cyc: got %0d, expected 28", ev_cyc[0][K_LONG][0]); end
        compared++; if (ev_cnt[0][K_REL] !== 1) begin mismatched++; $display("FAIL glitch_rel_count: got %0d, expected 1", ev_cnt[0][K_REL]); end
        compared++; if (ev_cyc[0][K_REL][0] !== 36) begin mismatched++; $display("FAIL glitch_rel_cyc: got %0d, expected 36", ev_cyc[0][K_REL][0]); end
        compared++; if (ev_cnt[0][K_RPT] !== 0) begin mismatched++; $display("FAIL glitch_rpt_count: got %0d, expected 0", ev_cnt[0][K_RPT]); end
        compared++; if (lvl_cnt[0] !== 30) begin mismatched++; $display("FAIL glitch_level_cycles: got %0d, expected 30", lvl_cnt[0]); end
    endtask

    task automatic test_both_keys();
        clear_log();
        KEY = 2'b00;
        repeat (6) tick();
        compared++; if (key_press !== 2'b11) begin mismatched++; $display("FAIL both_press_c6: got %b, expected 11", key_press); end
        while (cyc < 10) tick();
        KEY = 2'b10;                       // release key 1 only
        while (cyc < 14) tick();
        KEY = 2'b11;
        while (cyc < 26) tick();
        compared++; if (ev_cnt[0][K_PRESS] !== 1 || ev_cnt[1][K_PRESS] !== 1) begin mismatched++; $display("FAIL both_press_count: got %0d/%0d, expected 1/1", ev_cnt[0][K_PRESS], ev_cnt[1][K_PRESS]); end
        compared++; if (ev_cyc[1][K_REL][0] !== 16) begin mismatched++; $display("FAIL ch1_rel_cyc: got %0d, expected 16", ev_cyc[1][K_REL][0]); end
        compared++; if (ev_cyc[0][K_REL][0] !== 20) begin mismatched++; $display("FAIL ch0_rel_cyc: got %0d, expected 20", ev_cyc[0][K_REL][0]); end
        compared++; if (ev_cnt[0][K_LONG] + ev_cnt[1][K_LONG] !== 0) begin mismatched++; $display("FAIL both_no_long: got %0d, expected 0", ev_cnt[0][K_LONG] + ev_cnt[1][K_LONG]); end
    endtask

    task automatic test_reset_mid_hold();
        clear_log();
        KEY = 2'b10;
        while (cyc < 16) tick();           // 10 cycles into the hold
        RESET = 1'b1;
        tick();
        compared++; if ({key_level, key_press, key_rel, key_long, key_rpt} !== 10'b0) begin mismatched++; $display("FAIL midreset_outputs: got %b, expected all 0", {key_level, key_press, key_rel, key_long, key_rpt}); end
        RESET = 1'b0;
        clear_log();
        tick();
        compared++; if ({key_level, key_press, key_rel, key_long, key_rpt} !== 10'b0) begin mismatched++; $display("FAIL postreset_outputs: got %b, expected all 0", {key_level, key_press, key_rel, key_long, key_rpt}); end
        while (cyc < 30) tick();
        compared++; if (ev_cnt[0][K_PRESS] !== 1) begin mismatched++; $display("FAIL fresh_press_count: got %0d, expected 1", ev_cnt[0][K_PRESS]); end
        compared++; if (ev_cyc[0][K_PRESS][0] !== 6) begin mismatched++; $display("FAIL fresh_press_cyc: got %0d, expected 6", ev_cyc[0][K_PRESS][0]); end
        compared++; if (ev_cnt[0][K_LONG] !== 1) begin mismatched++; $display("FAIL fresh_long_count: got %0d, expected 1", ev_cnt[0][K_LONG]); end
        compared++; if (ev_cyc[0][K_LONG][0] !== 26) begin mismatched++; $display("FAIL fresh_long_cyc: got %0d, expected 26", ev_cyc[0][K_LONG][0]); end
        KEY = 2'b11;
        while (cyc < 40) tick();
        compared++; if (ev_cyc[0][K_REL][0] !== 36) begin mismatched++; $display("FAIL fresh_rel_cyc: got %0d, expected 36", ev_cyc[0][K_REL][0]); end
        compared++; if (ev_cnt[0][K_RPT] !== 0) begin mismatched++; $display("FAIL fresh_rpt_count: got %0d, expected 0", ev_cnt[0][K_RPT]); end
    endtask

    task automatic test_pulse_rules();
        compared++;
        if (pulse_viol !== 0) begin mismatched++; $display("FAIL pulse_rules: got %0d violations, expected 0", pulse_viol); end
    endtask

    initial begin
        RESET = 1'b1;
        KEY   = 2'b11;
        for (int ch = 0; ch < NK; ch++) prev_p[ch] = 4'b0;
        clear_log();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_release_glitch();
        test_both_keys();
        test_reset_mid_hold();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
